// File: rtl/bcd_updown_counter_param.sv
// N-digit packed-BCD up/down counter with programmable modulus, validated parallel load,
// terminal-count and wrap/load-error pulses. Define BCD_CNT_SATURATE_EN to saturate instead of wrapping.
module bcd_updown_counter_param #(
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned MOD_MAX = 999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] b;
    int unsigned  t;
    b = '0;
    t = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  if (DIGITS < 1 || DIGITS > 8 || MOD_MAX < 1 || MOD_MAX > pow10(DIGITS) - 1) begin : g_param_err
    $error("bcd_updown_counter_param: DIGITS/MOD_MAX out of range");
  end

  localparam logic [W-1:0] MAX_BCD = to_bcd(MOD_MAX);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic         lerr_q, lerr_d;

  logic         at_max, at_zero;
  logic         nibbles_ok, load_ok;
  logic [W-1:0] inc_val, dec_val;
  logic         carry, borrow;

  assign at_max  = (cnt_q == MAX_BCD);
  assign at_zero = (cnt_q == '0);

  // Once every nibble is 0-9, packed BCD orders the same as its binary reading.
  always_comb begin
    nibbles_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) nibbles_ok = 1'b0;
    end
    load_ok = nibbles_ok && (load_val <= MAX_BCD);
  end

  always_comb begin
    inc_val = cnt_q;
    dec_val = cnt_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (inc_val[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = inc_val[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (dec_val[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = dec_val[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    lerr_d = 1'b0;
    if (load) begin
      if (load_ok) cnt_d = load_val;
      else         lerr_d = 1'b1;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
`ifdef BCD_CNT_SATURATE_EN
          cnt_d = cnt_q;
`else
          cnt_d = '0;
`endif
          wrap_d = 1'b1;
        end else begin
          cnt_d = inc_val;
        end
      end else begin
        if (at_zero) begin
`ifdef BCD_CNT_SATURATE_EN
          cnt_d = cnt_q;
`else
          cnt_d = MAX_BCD;
`endif
          wrap_d = 1'b1;
        end else begin
          cnt_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      lerr_q <= lerr_d;
    end
  end

  assign cnt      = cnt_q;
  assign wrap     = wrap_q;
  assign load_err = lerr_q;
  assign tc       = en & ((up_dn & at_max) | (~up_dn & at_zero));

endmodule

// File: tb/tb_bcd_updown_counter_param.sv
// Directed bench for bcd_updown_counter_param: default 3-digit/999 instance plus a 2-digit/59 instance.
module tb_bcd_updown_counter_param;

`ifdef BCD_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, up_dn, load;
  logic [11:0] lv, cnt;
  logic        tc, wrap, lerr;

  logic        rst2, en2, up2, load2;
  logic [7:0]  lv2, cnt2;
  logic        tc2, wrap2, lerr2;

  int tests  = 0;
  int failed = 0;
  int e;
  logic wexp;

  bcd_updown_counter_param dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv),
    .cnt(cnt), .tc(tc), .wrap(wrap), .load_err(lerr)
  );

  bcd_updown_counter_param #(.DIGITS(2), .MOD_MAX(59)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .up_dn(up2), .load(load2), .load_val(lv2),
    .cnt(cnt2), .tc(tc2), .wrap(wrap2), .load_err(lerr2)
  );

  function automatic logic [11:0] b3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #1000000;
    $error("TIMEOUT: simulation did not finish");
    $finish;
  end

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b1; up_dn = 1'b1; lv = 12'h123;
    rst2 = 1'b1; en2 = 1'b0; load2 = 1'b0; up2 = 1'b1; lv2 = 8'h00;

    // reset dominates load and en
    tick;
    chk("rst_cnt0", cnt, 12'h000);
    chk("rst_wrap0", wrap, 1'b0);
    chk("rst_lerr0", lerr, 1'b0);
    tick;
    chk("rst_cnt1", cnt, 12'h000);
    chk("rst2_cnt", cnt2, 8'h00);
    rst = 1'b0; load = 1'b0; rst2 = 1'b0;
    tick;
    chk("first_inc", cnt, 12'h001);
    chk("first_wrap", wrap, 1'b0);
    chk("first_lerr", lerr, 1'b0);

    rst = 1'b1;
    tick;
    chk("midrst_cnt", cnt, 12'h000);
    rst = 1'b0;

    // full up sweep 0..999 and back to 0
    e = 0;
    for (int k = 0; k < 1000; k++) begin
      chk("sweep_tc", tc, (e == 999));
      tick;
      if (e == 999) begin e = SAT ? 999 : 0; wexp = 1'b1; end
      else begin e = e + 1; wexp = 1'b0; end
      chk("sweep_cnt", cnt, b3(e));
      chk("sweep_wrap", wrap, wexp);
    end
    en = 1'b0;
    #1;
    chk("idle_tc", tc, 1'b0);
    tick;
    chk("idle_wrap", wrap, 1'b0);
    chk("idle_hold", cnt, b3(e));

    // load with en: no step in a load cycle
    en = 1'b1; up_dn = 1'b0; load = 1'b1; lv = 12'h100;
    tick;
    chk("load_en_cnt", cnt, 12'h100);
    chk("load_en_lerr", lerr, 1'b0);
    load = 1'b0;
    tick;
    chk("dn_099", cnt, 12'h099);
    tick;
    chk("dn_098", cnt, 12'h098);

    load = 1'b1; lv = 12'h002;
    tick;
    load = 1'b0;
    tick;
    chk("dn_001", cnt, 12'h001);
    tick;
    chk("dn_000", cnt, 12'h000);
    chk("dn_000_wrap", wrap, 1'b0);
    #1;
    chk("dn_tc", tc, 1'b1);
    load = 1'b1; lv = 12'hABC;
    #1;
    chk("tc_ignores_load", tc, 1'b1);
    tick;
    chk("badload_cnt", cnt, 12'h000);
    chk("badload_lerr", lerr, 1'b1);
    chk("badload_wrap", wrap, 1'b0);
    load = 1'b0;
    tick;
    chk("dn_wrap_cnt", cnt, SAT ? 12'h000 : 12'h999);
    chk("dn_wrap_pulse", wrap, 1'b1);
    chk("dn_wrap_lerr", lerr, 1'b0);

    // direction flip
    load = 1'b1; lv = 12'h500;
    tick;
    load = 1'b0; up_dn = 1'b1;
    tick;
    chk("flip_501", cnt, 12'h501);
    up_dn = 1'b0;
    tick;
    chk("flip_500", cnt, 12'h500);

    // top-end behaviour from 998
    load = 1'b1; lv = 12'h998; up_dn = 1'b1;
    tick;
    load = 1'b0;
    tick;
    chk("top_999", cnt, 12'h999);
    chk("top_999_wrap", wrap, 1'b0);
    tick;
    chk("top_step2", cnt, SAT ? 12'h999 : 12'h000);
    chk("top_step2_wrap", wrap, 1'b1);
    tick;
    chk("top_step3", cnt, SAT ? 12'h999 : 12'h001);
    chk("top_step3_wrap", wrap, SAT);
    en = 1'b0;

    // 2-digit, modulus 59
    load2 = 1'b1; lv2 = 8'h58; en2 = 1'b1;
    tick;
    chk("m59_load58", cnt2, 8'h58);
    load2 = 1'b0;
    #1;
    chk("m59_tc0", tc2, 1'b0);
    tick;
    chk("m59_59", cnt2, 8'h59);
    chk("m59_tc1", tc2, 1'b1);
    tick;
    chk("m59_wrap_cnt", cnt2, SAT ? 8'h59 : 8'h00);
    chk("m59_wrap", wrap2, 1'b1);
    tick;
    chk("m59_after", cnt2, SAT ? 8'h59 : 8'h01);
    chk("m59_after_wrap", wrap2, SAT);
    en2 = 1'b0;
    tick;
    load2 = 1'b1; lv2 = 8'h60;
    tick;
    chk("m59_ld60_err", lerr2, 1'b1);
    chk("m59_ld60_cnt", cnt2, SAT ? 8'h59 : 8'h01);
    load2 = 1'b0;
    tick;
    chk("m59_err_clr", lerr2, 1'b0);
    load2 = 1'b1; lv2 = 8'h3A; en2 = 1'b1;
    tick;
    chk("m59_ld3A_err", lerr2, 1'b1);
    chk("m59_ld3A_cnt", cnt2, SAT ? 8'h59 : 8'h01);
    lv2 = 8'h45;
    tick;
    chk("m59_ld45_cnt", cnt2, 8'h45);
    chk("m59_ld45_err", lerr2, 1'b0);
    lv2 = 8'h00;
    tick;
    load2 = 1'b0; up2 = 1'b0;
    tick;
    chk("m59_dn_wrap_cnt", cnt2, SAT ? 8'h00 : 8'h59);
    chk("m59_dn_wrap", wrap2, 1'b1);
    en2 = 1'b0;
    tick;
    chk("m59_idle_wrap", wrap2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
